// File: rtl/my_xor_frame_acc.sv
// Folds a valid/ready stream of words into one XOR word plus a parity bit per frame.
// Latency: result 1 cycle after the closing word. Backpressure: in_ready is low while the result waits.
module my_xor_frame_acc #(
  parameter int  WIDTH     = 8,
  parameter int  MAX_WORDS = 16,
  localparam int CNT_W     = $clog2(MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             odd_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_word,
  output logic             out_bit,
  output logic [CNT_W-1:0] out_count,
  output logic             out_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   acc_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               mode;
  logic               mode_nxt;
  logic               accept;
  logic               close;

  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The first word of a frame seeds the accumulator and latches the parity mode.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc ^ in_data;
    cnt_nxt   = cnt + CNT_W'(1);
    mode_nxt  = mode;
    if (state == IDLE) begin
      acc_nxt  = in_data;
      cnt_nxt  = CNT_W'(1);
      mode_nxt = odd_mode;
    end
    close = accept && (in_last || (cnt_nxt == CNT_W'(MAX_WORDS)));
    case (state)
      IDLE, ACC: begin
        if (accept) begin
          state_nxt = close ? HOLD : ACC;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      mode      <= 1'b0;
      out_word  <= '0;
      out_bit   <= 1'b0;
      out_count <= '0;
      out_err   <= 1'b0;
    end else if (accept) begin
      acc  <= acc_nxt;
      cnt  <= cnt_nxt;
      mode <= mode_nxt;
      if (close) begin
        out_word  <= acc_nxt;
        out_bit   <= (^acc_nxt) ^ mode_nxt;
        out_count <= cnt_nxt;
        out_err   <= ~in_last;
      end
    end else if (out_valid && out_ready) begin
      acc <= '0;
      cnt <= '0;
    end
  end

endmodule
